mem_bist_master: RTL
====================

// Module: mem_bist_master
// PURPOSE
//  Built-in self-test initiator for the single-port memory model. Drives its addr/wr_en/rd_en/wdata
//  pins and checks rdata. On start: writes a deterministic pattern to every address, reads every
//  address back, compares against expectation, reports pass/fail plus first-failure details.
//  Sits between the test/control logic and the memory instance, in place of the normal master.
// PARAMETERS
//  ADDR_WIDTH  8      memory address width; DEPTH = 2**ADDR_WIDTH locations tested
//  DATA_WIDTH  8      memory data width
//  SEED        8'hA5  DATA_WIDTH-bit XOR seed; pattern(a) = DATA_WIDTH'(a) ^ SEED
// PORTS
//  clk        in   1           clock, all flops on posedge
//  reset      in   1           asynchronous, active-high reset
//  start      in   1           1-cycle request; honoured only in IDLE or DONE
//  busy       out  1           high from cycle after accepted start until DONE entered
//  done       out  1           level; high in DONE until next accepted start or reset
//  pass       out  1           done && err_count==0; 0 otherwise
//  err_count  out  ADDR_WIDTH+2  number of mismatching reads this run (cannot overflow)
//  fail_addr  out  ADDR_WIDTH  address of first mismatch (0 if none)
//  fail_data  out  DATA_WIDTH  rdata captured at first mismatch (0 if none)
//  mem_addr   out  ADDR_WIDTH  to memory addr
//  mem_wr_en  out  1           to memory wr_en
//  mem_rd_en  out  1           to memory rd_en
//  mem_wdata  out  DATA_WIDTH  to memory wdata
//  mem_rdata  in   DATA_WIDTH  from memory rdata; valid the cycle after mem_rd_en
// BEHAVIOUR
//  Reset: state=IDLE; every output 0; counters/capture regs 0. Reset mid-run aborts immediately.
//  FSM: IDLE -start-> WRITE -cnt==DEPTH-1-> READ -cnt==DEPTH-1-> DRAIN -> DONE -start-> WRITE.
//   WRITE: mem_wr_en=1, mem_addr=cnt, mem_wdata=pattern(cnt); cnt++ each cycle.
//   READ : mem_rd_en=1, mem_addr=cnt; cnt++ each cycle. DRAIN: 1 cycle, no access, last compare.
//   cnt resets to 0 on every phase entry; wr_en and rd_en never both high.
//  mem_* decoded only from state/cnt flops: no combinational path from any input.
//  Check pipeline: read issued cycle N -> exp=pattern(addr), chk_vld set for cycle N+1;
//   in N+1 if chk_vld && mem_rdata!=exp: err_count++; if first error, latch fail_addr/fail_data.
//  Accepted start clears err_count, fail_addr, fail_data, done, pass. start while busy: ignored.
//  Latency: done rises 2*DEPTH+2 cycles after start-sampling edge (WRITE+READ+DRAIN+1).
//  Memory rdata before first read (e.g. 0xFF reset fill) is never compared: chk_vld gates it.
// CONFIGURATION
//  MEM_BIST_INV_PASS_EN defined: after READ, adds WRITE_INV then READ_INV (data=~pattern(a)),
//   then DRAIN; compare continuous across the READ->WRITE_INV boundary; latency 4*DEPTH+2.
//  Undefined: single true-pattern pass only; WRITE_INV/READ_INV states do not exist.
// STRUCTURE
//  mem_bist_pkg: state enum (IDLE,WRITE,READ,WRITE_INV,READ_INV,DRAIN,DONE), pattern() function.
//  Sub-module mem_bist_checker: chk_vld/exp/addr pipeline, compare, err_count, first-fail capture.
// TESTING (ADDR_WIDTH=4, DATA_WIDTH=8, SEED=8'hA5, memory model attached)
//  Clean run: start pulse -> busy for 33 cycles, done=1, pass=1, err_count=0, 16 writes/16 reads.
//  Fault: invert rdata bit0 on read of addr 5 -> err_count=1, fail_addr=5, fail_data=8'hA1, pass=0.
//  Two faults (addr 3, addr 9) -> err_count=2, fail_addr=3 (first only retained).
//  start pulsed while busy at cycle 10 -> ignored; done still at cycle 34, single run.
//  reset asserted mid-WRITE (cycle 5) -> all outputs 0 same cycle; fresh start -> clean pass.
//  INV_PASS_EN: bit0 stuck-at-1 at addr 2 -> done after 66 cycles, err_count=1, fail_addr=2,
//   fail_data=8'h59; same fault without macro -> pass=1.

Source files
------------

// File: rtl/mem_bist_pkg.sv
// Shared types and helpers for the memory BIST master.
// MEM_BIST_INV_PASS_EN adds the inverted-pattern write/read pass.
package mem_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
`ifdef MEM_BIST_INV_PASS_EN
    WRITE_INV,
    READ_INV,
`endif
    DRAIN,
    DONE
  } state_t;

  // Wide enough for any practical address/data width; callers truncate.
  localparam int PAT_W = 64;

  function automatic logic [PAT_W-1:0] pattern(input logic [PAT_W-1:0] a,
                                               input logic [PAT_W-1:0] seed);
    return a ^ seed;
  endfunction

endpackage

// File: rtl/mem_bist_checker.sv
// Read-check pipeline: registers expected data/address with each read, compares
// against rdata one cycle later, counts mismatches and captures the first one.
module mem_bist_checker #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  rd_issue,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_exp,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH+1:0] err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data
);

  logic                  chk_vld;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] exp_q;
  logic                  mismatch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_vld <= 1'b0;
      addr_q  <= '0;
      exp_q   <= '0;
    end else begin
      chk_vld <= rd_issue;
      if (rd_issue) begin
        addr_q <= rd_addr;
        exp_q  <= rd_exp;
      end
    end
  end

  // chk_vld keeps stale rdata (e.g. the memory's power-up fill) out of the compare.
  assign mismatch = chk_vld && (rdata != exp_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= '0;
      fail_addr <= '0;
      fail_data <= '0;
    end else if (clear) begin
      err_count <= '0;
      fail_addr <= '0;
      fail_data <= '0;
    end else if (mismatch) begin
      err_count <= err_count + 1'b1;
      if (err_count == '0) begin
        fail_addr <= addr_q;
        fail_data <= rdata;
      end
    end
  end

endmodule

// File: rtl/mem_bist_master.sv
// March-style BIST initiator: writes pattern(a) = a ^ SEED everywhere, reads it back,
// reports pass/fail. Define MEM_BIST_INV_PASS_EN for an extra inverted-data pass.
module mem_bist_master
  import mem_bist_pkg::*;
#(
  parameter int                  ADDR_WIDTH = 8,
  parameter int                  DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] SEED     = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH+1:0] err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  accept;
  logic                  last;
  logic                  inv;
  logic [DATA_WIDTH-1:0] pat;
  logic [DATA_WIDTH-1:0] pat_cur;

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = WRITE;
      WRITE:      if (last)  state_nxt = READ;
`ifdef MEM_BIST_INV_PASS_EN
      READ:       if (last)  state_nxt = WRITE_INV;
      WRITE_INV:  if (last)  state_nxt = READ_INV;
      READ_INV:   if (last)  state_nxt = DRAIN;
`else
      READ:       if (last)  state_nxt = DRAIN;
`endif
      DRAIN:                 state_nxt = DONE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Counter restarts on every phase change so each phase sweeps 0..DEPTH-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   cnt <= '0;
    else if (state_nxt != state) cnt <= '0;
    else if (mem_wr_en || mem_rd_en) cnt <= cnt + 1'b1;
  end

  // Memory pins decode only from state/cnt flops, never from start or rdata.
  always_comb begin
    mem_wr_en = 1'b0;
    mem_rd_en = 1'b0;
    inv       = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      WRITE:     begin mem_wr_en = 1'b1; busy = 1'b1; end
      READ:      begin mem_rd_en = 1'b1; busy = 1'b1; end
`ifdef MEM_BIST_INV_PASS_EN
      WRITE_INV: begin mem_wr_en = 1'b1; inv = 1'b1; busy = 1'b1; end
      READ_INV:  begin mem_rd_en = 1'b1; inv = 1'b1; busy = 1'b1; end
`endif
      DRAIN:     busy = 1'b1;
      DONE:      done = 1'b1;
      default:   ;
    endcase
  end

  assign pat       = DATA_WIDTH'(pattern(PAT_W'(cnt), PAT_W'(SEED)));
  assign pat_cur   = inv ? ~pat : pat;
  assign mem_addr  = (mem_wr_en || mem_rd_en) ? cnt : '0;
  assign mem_wdata = mem_wr_en ? pat_cur : '0;
  assign pass      = done && (err_count == '0);

  mem_bist_checker #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_checker (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept),
    .rd_issue  (mem_rd_en),
    .rd_addr   (cnt),
    .rd_exp    (pat_cur),
    .rdata     (mem_rdata),
    .err_count (err_count),
    .fail_addr (fail_addr),
    .fail_data (fail_data)
  );

endmodule
